ptcalc_top_div_iter: RTL and testbench

- Iterative signed divider; the inverse of the ptcalc 15x15 signed multiply (30-bit product).
- Divides a 30-bit signed dividend by a 15-bit signed divisor, giving a saturated 15-bit signed quotient and a 15-bit signed remainder.
- Used in the pT-calc datapath to recover sagitta-normalised terms.
- Valid/ready in, valid/ready out; one operation in flight.

---
 rtl/ptcalc_pkg.sv | 22 ++
 rtl/ptcalc_div_sat.sv | 44 ++++
 rtl/ptcalc_top_div_iter.sv | 155 +++++++++++++++
 tb/tb_ptcalc_top_div_iter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ptcalc_pkg.sv
// ptcalc shared definitions: datapath widths, divider FSM states, quotient saturation limits.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ptcalc_pkg;

    localparam int DIVIDEND_W = 30;
    localparam int DIVISOR_W  = 15;
    localparam int QUOT_W     = 15;

    // Bit counter wide enough to hold DIVIDEND_W-1.
    localparam int CNT_W = $clog2(DIVIDEND_W);

    localparam logic [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ptcalc_div_sat.sv
// Sign-apply plus saturation of an unsigned magnitude to a narrower signed result.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: mag_i (unsigned magnitude), neg_i (result is negative),
//        val_o (signed saturated value), ovf_o (saturation occurred).
module ptcalc_div_sat #(
    parameter int IN_W  = 30,
    parameter int OUT_W = 15
) (
    input  logic [IN_W-1:0]  mag_i,
    input  logic             neg_i,
    output logic [OUT_W-1:0] val_o,
    output logic             ovf_o
);

    // Largest magnitudes representable on each side of zero.
    localparam logic [IN_W-1:0] POS_LIM = IN_W'((64'd1 << (OUT_W-1)) - 64'd1);
    localparam logic [IN_W-1:0] NEG_LIM = IN_W'(64'd1 << (OUT_W-1));

    logic [OUT_W-1:0] mag_lo;

    always_comb begin
        mag_lo = mag_i[OUT_W-1:0];
        val_o  = '0;
        ovf_o  = 1'b0;
        if (neg_i) begin
            if (mag_i > NEG_LIM) begin
                val_o = {1'b1, {(OUT_W-1){1'b0}}};
                ovf_o = 1'b1;
            end else begin
                // Low-bit negation; exact because |mag| <= 2^(OUT_W-1) here.
                val_o = ~mag_lo + OUT_W'(1);
            end
        end else begin
            if (mag_i > POS_LIM) begin
                val_o = {1'b0, {(OUT_W-1){1'b1}}};
                ovf_o = 1'b1;
            end else begin
                val_o = mag_lo;
            end
        end
    end

endmodule

// File: rtl/ptcalc_top_div_iter.sv
// Iterative restoring signed divider (30b / 15b) with saturated quotient and exact remainder.
// Latency: 31 cycles from accept to out_valid (1 cycle on divide-by-zero); one op in flight.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Ports: ap_clk/ap_rst, in_valid/in_ready + dividend/divisor operands,
//        out_valid/out_ready + quotient/remainder/div_by_zero/overflow result.
module ptcalc_top_div_iter
    import ptcalc_pkg::*;
(
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [QUOT_W-1:0]     quotient,
    output logic signed [DIVISOR_W-1:0]  remainder,
    output logic                        div_by_zero,
    output logic                        overflow
);

    state_t                state_q, state_d;
    // Dividend magnitude shifts out MSB-first; quotient bits shift in at the LSB.
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;

    // One restoring step. The working partial remainder is DIVISOR_W+1 bits;
    // the stored one fits DIVISOR_W bits since it is always below |divisor| <= 2^(DIVISOR_W-1).
    logic [DIVISOR_W:0]    shift;
    logic [DIVISOR_W:0]    diff;
    logic                  ge;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVIDEND_W-1:0] dvd_nxt;
    logic [QUOT_W-1:0]     sat_val;
    logic                  sat_ovf;

    always_comb begin
        shift   = {rem_q, dvd_q[DIVIDEND_W-1]};
        diff    = shift - {1'b0, dvs_q};
        // Borrow bit is a reliable sign: shift < 2^DIVISOR_W and dvs <= 2^(DIVISOR_W-1).
        ge      = ~diff[DIVISOR_W];
        rem_nxt = ge ? diff[DIVISOR_W-1:0] : shift[DIVISOR_W-1:0];
        dvd_nxt = {dvd_q[DIVIDEND_W-2:0], ge};
    end

    // Fed the final quotient magnitude so the result registers on entry to DONE.
    ptcalc_div_sat #(
        .IN_W  (DIVIDEND_W),
        .OUT_W (QUOT_W)
    ) u_sat (
        .mag_i (dvd_nxt),
        .neg_i (q_neg_q),
        .val_o (sat_val),
        .ovf_o (sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quot_d  = dividend[DIVIDEND_W-1] ? QUOT_MIN : QUOT_MAX;
                        rmd_d   = '0;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        // Two's-complement negation yields the correct unsigned magnitude even for the most negative value.
                        dvd_d   = dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-dividend) : DIVIDEND_W'(dividend);
                        dvs_d   = divisor[DIVISOR_W-1] ? DIVISOR_W'(-divisor) : DIVISOR_W'(divisor);
                        rem_d   = '0;
                        cnt_d   = CNT_W'(DIVIDEND_W-1);
                        q_neg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                        r_neg_d = dividend[DIVIDEND_W-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = dvd_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quot_d  = sat_val;
                    ovf_d   = sat_ovf;
                    dz_d    = 1'b0;
                    rmd_d   = r_neg_q ? (~rem_nxt + DIVISOR_W'(1)) : rem_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ptcalc_top_div_iter.sv
// Bench for ptcalc_top_div_iter: arithmetic reference model plus directed vectors.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_ptcalc_top_div_iter;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [29:0] dividend;
    logic signed [14:0] divisor;
    logic               out_valid;
    logic               out_ready;
    logic signed [14:0] quotient;
    logic signed [14:0] remainder;
    logic               div_by_zero;
    logic               overflow;

    int checks   = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    ptcalc_top_div_iter dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        longint q;
        longint r;
        bit     dz;
        bit     ov;
    } res_t;

    res_t exp_q[$];

    // Reference: plain integer division (truncates toward zero, remainder takes dividend sign).
    function automatic res_t model(longint a, longint b);
        res_t m;
        m.dz = 1'b0;
        m.ov = 1'b0;
        if (b == 0) begin
            m.dz = 1'b1;
            m.r  = 0;
            m.q  = (a >= 0) ? 16383 : -16384;
        end else begin
            m.q = a / b;
            m.r = a % b;
            if (m.q > 16383) begin
                m.q  = 16383;
                m.ov = 1'b1;
            end else if (m.q < -16384) begin
                m.q  = -16384;
                m.ov = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Track accepted operations and consumed results.
    always @(posedge ap_clk) begin
        if (ap_rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(longint'(dividend), longint'(divisor)));
        end
    end

    // Every cycle a result is presented, it must match the model's oldest pending result.
    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("mdl_quotient", longint'(quotient), exp_q[0].q);
                chk("mdl_remainder", longint'(remainder), exp_q[0].r);
                chk("mdl_div_by_zero", longint'(div_by_zero), longint'(exp_q[0].dz));
                chk("mdl_overflow", longint'(overflow), longint'(exp_q[0].ov));
                chk("mdl_in_ready_in_done", longint'(in_ready), 0);
            end
        end
    end

    task automatic run_op(input longint a, input longint b, input longint eq, input longint er,
                          input bit edz, input bit eov, input int elat);
        int cyc;
        chk("pre_in_ready", longint'(in_ready), 1);
        dividend  = 30'(a);
        divisor   = 15'(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(posedge ap_clk);
            #1;
            cyc++;
        end
        chk("latency", longint'(cyc), longint'(elat));
        chk("quotient", longint'(quotient), eq);
        chk("remainder", longint'(remainder), er);
        chk("div_by_zero", longint'(div_by_zero), longint'(edz));
        chk("overflow", longint'(overflow), longint'(eov));
        @(posedge ap_clk);
        #1;
        chk("post_out_valid", longint'(out_valid), 0);
        chk("post_in_ready", longint'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_quotient", longint'(quotient), 0);
        chk("rst_remainder", longint'(remainder), 0);
        chk("rst_div_by_zero", longint'(div_by_zero), 0);
        chk("rst_overflow", longint'(overflow), 0);
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;

        //      dividend     divisor  quot    rem  dz ov lat
        run_op(1000,         7,       142,    6,   0, 0, 31);
        run_op(-1000,        7,       -142,   -6,  0, 0, 31);
        run_op(1000,         -7,      -142,   6,   0, 0, 31);
        run_op(-30,          -7,      4,      -2,  0, 0, 31);
        run_op(268435456,    1,       16383,  0,   0, 1, 31);
        run_op(-268435456,   1,       -16384, 0,   0, 1, 31);
        run_op(-16384,       1,       -16384, 0,   0, 0, 31);
        run_op(16384,        -1,      -16384, 0,   0, 0, 31);
        run_op(-536870912,   -1,      16383,  0,   0, 1, 31);
        run_op(500,          0,       16383,  0,   1, 0, 1);
        run_op(-500,         0,       -16384, 0,   1, 0, 1);

        // Backpressure: result held for 10 cycles, a second request is ignored.
        dividend  = 30'sd1000;
        divisor   = 15'sd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(posedge ap_clk);
            #1;
            cyc++;
        end
        chk("bp_latency", longint'(cyc), 31);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_quotient", longint'(quotient), 142);
            chk("bp_remainder", longint'(remainder), 6);
            if (i == 3) begin
                dividend = 30'sd77;
                divisor  = 15'sd5;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge ap_clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("bp_release_out_valid", longint'(out_valid), 0);
        chk("bp_release_in_ready", longint'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_no_ghost_result", longint'(seen), 0);

        // Reset in CALC cycle 12 discards the operation.
        dividend = 30'sd1000;
        divisor  = 15'sd7;
        in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (11) begin
            @(posedge ap_clk);
            #1;
        end
        chk("mid_calc_in_ready", longint'(in_ready), 0);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", longint'(seen), 0);
        run_op(1000, 7, 142, 6, 0, 0, 31);

        repeat (2) @(posedge ap_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
